// File: rtl/midi_voice_allocator_pkg.sv
// Shared constants for the MIDI voice allocator: MIDI status nibbles, controller
// numbers, FSM state encodings and a small channel-filter helper.
package midi_voice_allocator_pkg;

  // MIDI status high nibbles
  localparam logic [3:0] MidiNoteOff = 4'h8;
  localparam logic [3:0] MidiNoteOn  = 4'h9;
  localparam logic [3:0] MidiCc      = 4'hB;

  // Controller numbers
  localparam logic [6:0] CcSustain     = 7'd64;
  localparam logic [6:0] CcAllNotesOff = 7'd123;

  // FSM state encodings
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StScan  = 2'd1;
  localparam logic [1:0] StApply = 2'd2;

  // True when MIDI channel chan is enabled in mask.
  function automatic logic chan_enabled(input logic [15:0] mask, input logic [3:0] chan);
    return mask[chan];
  endfunction

endpackage

// File: rtl/midi_voice_allocator_voice_slot.sv
// One voice slot: stores note, velocity, gate, sustain-held flag and a saturating age.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   assign_en     (re)assign this slot to note_in/vel_in, gate on, age 0, trig pulse
//   release_en    gate off, held cleared (note-off without sustain)
//   hold_en       mark held (note-off while sustain pedal is down)
//   release_held  sustain pedal released: a held slot drops gate
//   clear_all     all-notes-off: gate and held cleared
//   age_en        another slot was assigned; increment age (saturating)
//   note_in/vel_in note and velocity to load on assign
//   gate/held/trig/note/vel/age slot state
module midi_voice_allocator_voice_slot #(
  parameter int unsigned AGE_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                assign_en,
  input  logic                release_en,
  input  logic                hold_en,
  input  logic                release_held,
  input  logic                clear_all,
  input  logic                age_en,
  input  logic [6:0]          note_in,
  input  logic [6:0]          vel_in,
  output logic                gate,
  output logic                held,
  output logic                trig,
  output logic [6:0]          note,
  output logic [6:0]          vel,
  output logic [AGE_BITS-1:0] age
);

  localparam logic [AGE_BITS-1:0] AgeMax = {AGE_BITS{1'b1}};

  logic                gate_q, held_q, trig_q;
  logic [6:0]          note_q, vel_q;
  logic [AGE_BITS-1:0] age_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= 1'b0;
      held_q <= 1'b0;
      trig_q <= 1'b0;
      note_q <= '0;
      vel_q  <= '0;
      age_q  <= '0;
    end else begin
      trig_q <= assign_en && !clear_all;
      if (clear_all) begin
        gate_q <= 1'b0;
        held_q <= 1'b0;
      end else if (assign_en) begin
        gate_q <= 1'b1;
        held_q <= 1'b0;
        note_q <= note_in;
        vel_q  <= vel_in;
        age_q  <= '0;
      end else begin
        if (release_en || (release_held && held_q)) begin
          gate_q <= 1'b0;
          held_q <= 1'b0;
        end else if (hold_en) begin
          held_q <= 1'b1;
        end
        if (age_en && age_q != AgeMax) begin
          age_q <= age_q + 1'b1;
        end
      end
    end
  end

  assign gate = gate_q;
  assign held = held_q;
  assign trig = trig_q;
  assign note = note_q;
  assign vel  = vel_q;
  assign age  = age_q;

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic MIDI voice allocator. Accepts parsed MIDI messages and assigns notes to
// NUM_VOICES slots with retrigger, oldest-voice stealing, sustain pedal, all-notes-off
// and a per-channel filter. Note messages go IDLE -> SCAN (one voice per cycle) -> APPLY.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            message handshake; in_ready is high only in IDLE
//   in_status/in_data1/in_data2  MIDI status, note/CC number, velocity/CC value
//   voice_gate/voice_trig        per-voice gate and 1-cycle (re)assign pulse
//   voice_note/voice_vel         per-voice note/velocity, voice i at [7i+6:7i]
module midi_voice_allocator
  import midi_voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 4,
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
  parameter int unsigned AGE_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_status,
  input  logic [6:0]              in_data1,
  input  logic [6:0]              in_data2,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel
);

  localparam int unsigned IdxW = $clog2(NUM_VOICES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VOICES - 1);

  logic [1:0]          state_q, state_d;
  logic [IdxW-1:0]     scan_idx_q, scan_idx_d;
  logic                is_on_q, is_on_d;
  logic [6:0]          note_q, note_d, vel_q, vel_d;
  logic                match_found_q, match_found_d, free_found_q, free_found_d;
  logic [IdxW-1:0]     match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [IdxW-1:0]     old_idx_q, old_idx_d;
  logic [AGE_BITS-1:0] old_age_q, old_age_d;
  logic                sustain_q, sustain_d;

  logic [NUM_VOICES-1:0] gate_w, held_w, trig_w;
  logic [6:0]            note_w [NUM_VOICES];
  logic [6:0]            vel_w  [NUM_VOICES];
  logic [AGE_BITS-1:0]   age_w  [NUM_VOICES];

  logic [NUM_VOICES-1:0] assign_v, release_v, hold_v, age_v;

  // Input decode
  logic       xfer, chan_ok, note_on_in, note_off_in, cc_in;
  logic       sus_set, sus_clr, all_off;
  logic [3:0] kind;

  assign in_ready = (state_q == StIdle);
  assign xfer     = in_valid && in_ready;
  assign kind     = in_status[7:4];
  assign chan_ok  = chan_enabled(CHANNEL_MASK, in_status[3:0]);

  assign note_on_in  = chan_ok && (kind == MidiNoteOn) && (in_data2 != 7'd0);
  assign note_off_in = chan_ok && ((kind == MidiNoteOff) ||
                                   ((kind == MidiNoteOn) && (in_data2 == 7'd0)));
  assign cc_in       = chan_ok && (kind == MidiCc);

  assign sus_set = xfer && cc_in && (in_data1 == CcSustain) && in_data2[6];
  assign sus_clr = xfer && cc_in && (in_data1 == CcSustain) && !in_data2[6];
  assign all_off = xfer && cc_in && (in_data1 == CcAllNotesOff);

  // Voice currently under the scan pointer
  logic                cur_gate, cur_match;
  logic [AGE_BITS-1:0] cur_age;

  assign cur_gate  = gate_w[scan_idx_q];
  assign cur_age   = age_w[scan_idx_q];
  assign cur_match = cur_gate && (note_w[scan_idx_q] == note_q);

  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    is_on_d       = is_on_q;
    note_d        = note_q;
    vel_d         = vel_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    sustain_d     = sustain_q;

    unique case (state_q)
      StIdle: begin
        if (xfer && (note_on_in || note_off_in)) begin
          state_d    = StScan;
          scan_idx_d = '0;
          is_on_d    = note_on_in;
          note_d     = in_data1;
          vel_d      = in_data2;
        end
      end
      StScan: begin
        if (scan_idx_q == '0) begin
          // First visit seeds every candidate
          match_found_d = cur_match;
          match_idx_d   = '0;
          free_found_d  = !cur_gate;
          free_idx_d    = '0;
          old_idx_d     = '0;
          old_age_d     = cur_age;
        end else begin
          if (!match_found_q && cur_match) begin
            match_found_d = 1'b1;
            match_idx_d   = scan_idx_q;
          end
          if (!free_found_q && !cur_gate) begin
            free_found_d = 1'b1;
            free_idx_d   = scan_idx_q;
          end
          // Strictly greater keeps the lowest index on ties
          if (cur_age > old_age_q) begin
            old_idx_d = scan_idx_q;
            old_age_d = cur_age;
          end
        end
        if (scan_idx_q == LastIdx) begin
          state_d = StApply;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      StApply: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (all_off) begin
      sustain_d = 1'b0;
    end else if (sus_set) begin
      sustain_d = 1'b1;
    end else if (sus_clr) begin
      sustain_d = 1'b0;
    end
  end

  // Per-voice strobes, active only in APPLY
  logic            applying;
  logic [IdxW-1:0] target;

  assign applying = (state_q == StApply);
  assign target   = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : old_idx_q);

  always_comb begin
    assign_v  = '0;
    release_v = '0;
    hold_v    = '0;
    age_v     = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (applying && is_on_q) begin
        assign_v[i] = (target == IdxW'(i));
        age_v[i]    = (target != IdxW'(i)) && gate_w[i];
      end
      if (applying && !is_on_q && match_found_q && (match_idx_q == IdxW'(i))) begin
        release_v[i] = !sustain_q;
        hold_v[i]    = sustain_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      scan_idx_q    <= '0;
      is_on_q       <= 1'b0;
      note_q        <= '0;
      vel_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      sustain_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      is_on_q       <= is_on_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      sustain_q     <= sustain_d;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    midi_voice_allocator_voice_slot #(
      .AGE_BITS(AGE_BITS)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .assign_en   (assign_v[i]),
      .release_en  (release_v[i]),
      .hold_en     (hold_v[i]),
      .release_held(sus_clr),
      .clear_all   (all_off),
      .age_en      (age_v[i]),
      .note_in     (note_q),
      .vel_in      (vel_q),
      .gate        (gate_w[i]),
      .held        (held_w[i]),
      .trig        (trig_w[i]),
      .note        (note_w[i]),
      .vel         (vel_w[i]),
      .age         (age_w[i])
    );
    assign voice_note[7*i +: 7] = note_w[i];
    assign voice_vel[7*i +: 7]  = vel_w[i];
  end

  assign voice_gate = gate_w;
  assign voice_trig = trig_w;

endmodule

// File: tb/tb_midi_voice_allocator.sv
module tb_midi_voice_allocator;

  localparam int unsigned NV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_status = '0;
  logic [6:0]    in_data1 = '0;
  logic [6:0]    in_data2 = '0;
  logic [NV-1:0] voice_gate, voice_trig;
  logic [7*NV-1:0] voice_note, voice_vel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  midi_voice_allocator #(
    .NUM_VOICES  (NV),
    .CHANNEL_MASK(16'h0001),
    .AGE_BITS    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_status (in_status),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .voice_gate(voice_gate),
    .voice_trig(voice_trig),
    .voice_note(voice_note),
    .voice_vel (voice_vel)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Presents one message for one cycle; returns #1 after the transfer edge.
  task automatic send(input logic [7:0] s, input logic [6:0] d1, input logic [6:0] d2);
    @(negedge clk);
    in_valid = 1'b1;
    in_status = s;
    in_data1 = d1;
    in_data2 = d2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // After send() of a note message: the outputs are updated 5 edges after transfer.
  task automatic wait_note();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (voice_gate !== 4'b0) begin failures++; $display("FAIL reset_gate got %h want 0", voice_gate); end
    checks++; if (voice_trig !== 4'b0) begin failures++; $display("FAIL reset_trig got %h want 0", voice_trig); end
    checks++; if (voice_note !== 28'b0) begin failures++; $display("FAIL reset_note got %h want 0", voice_note); end
    checks++; if (voice_vel !== 28'b0) begin failures++; $display("FAIL reset_vel got %h want 0", voice_vel); end
    do_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_note_on();
    do_reset();
    send(8'h90, 7'd60, 7'd100);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL non_busy got %b want 0", in_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (voice_trig !== 4'b0) begin failures++; $display("FAIL non_early_trig got %h want 0", voice_trig); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL non_ready_apply got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (voice_trig !== 4'b0001) begin failures++; $display("FAIL non_trig got %h want 1", voice_trig); end
    checks++; if (voice_gate !== 4'b0001) begin failures++; $display("FAIL non_gate got %h want 1", voice_gate); end
    checks++; if (voice_note[6:0] !== 7'd60) begin failures++; $display("FAIL non_note got %0d want 60", voice_note[6:0]); end
    checks++; if (voice_vel[6:0] !== 7'd100) begin failures++; $display("FAIL non_vel got %0d want 100", voice_vel[6:0]); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL non_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (voice_trig !== 4'b0) begin failures++; $display("FAIL non_trig_pulse got %h want 0", voice_trig); end
  endtask

  task automatic test_fill_and_steal();
    do_reset();
    send(8'h90, 7'd60, 7'd10); wait_note();
    send(8'h90, 7'd62, 7'd20); wait_note();
    send(8'h90, 7'd64, 7'd30); wait_note();
    send(8'h90, 7'd65, 7'd40); wait_note();
    checks++; if (voice_gate !== 4'b1111) begin failures++; $display("FAIL fill_gate got %h want f", voice_gate); end
    checks++; if (voice_note !== {7'd65, 7'd64, 7'd62, 7'd60}) begin
      failures++; $display("FAIL fill_note got %h want %h", voice_note, {7'd65, 7'd64, 7'd62, 7'd60}); end
    send(8'h90, 7'd67, 7'd50); wait_note();
    checks++; if (voice_trig !== 4'b0001) begin failures++; $display("FAIL steal_trig got %h want 1", voice_trig); end
    checks++; if (voice_note !== {7'd65, 7'd64, 7'd62, 7'd67}) begin
      failures++; $display("FAIL steal_note got %h want %h", voice_note, {7'd65, 7'd64, 7'd62, 7'd67}); end
    checks++; if (voice_vel[6:0] !== 7'd50) begin failures++; $display("FAIL steal_vel got %0d want 50", voice_vel[6:0]); end
    // Ages now v0=0 v1=3 v2=2 v3=1, so the next steal takes voice1
    send(8'h90, 7'd70, 7'd55); wait_note();
    checks++; if (voice_trig !== 4'b0010) begin failures++; $display("FAIL steal2_trig got %h want 2", voice_trig); end
  endtask

  task automatic test_note_off_vel0();
    do_reset();
    send(8'h90, 7'd60, 7'd100); wait_note();
    send(8'h90, 7'd60, 7'd0); wait_note();
    checks++; if (voice_gate !== 4'b0) begin failures++; $display("FAIL off_gate got %h want 0", voice_gate); end
    checks++; if (voice_note[6:0] !== 7'd60) begin failures++; $display("FAIL off_note got %0d want 60", voice_note[6:0]); end
    checks++; if (voice_vel[6:0] !== 7'd100) begin failures++; $display("FAIL off_vel got %0d want 100", voice_vel[6:0]); end
    checks++; if (voice_trig !== 4'b0) begin failures++; $display("FAIL off_trig got %h want 0", voice_trig); end
  endtask

  task automatic test_sustain();
    do_reset();
    send(8'h90, 7'd60, 7'd100); wait_note();
    send(8'h90, 7'd62, 7'd100); wait_note();
    send(8'hB0, 7'd64, 7'd127);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sus_ready got %b want 1", in_ready); end
    send(8'h80, 7'd62, 7'd0); wait_note();
    checks++; if (voice_gate !== 4'b0011) begin failures++; $display("FAIL sus_hold got %h want 3", voice_gate); end
    send(8'hB0, 7'd64, 7'd0);
    checks++; if (voice_gate !== 4'b0001) begin failures++; $display("FAIL sus_release got %h want 1", voice_gate); end
    checks++; if (voice_note[13:7] !== 7'd62) begin failures++; $display("FAIL sus_note got %0d want 62", voice_note[13:7]); end
  endtask

  task automatic test_channel_filter();
    do_reset();
    send(8'h91, 7'd60, 7'd100);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL chan_ready got %b want 1", in_ready); end
    send(8'hA0, 7'd60, 7'd100);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL unk_ready got %b want 1", in_ready); end
    wait_note();
    checks++; if (voice_gate !== 4'b0) begin failures++; $display("FAIL chan_gate got %h want 0", voice_gate); end
    checks++; if (voice_note !== 28'b0) begin failures++; $display("FAIL chan_note got %h want 0", voice_note); end
  endtask

  task automatic test_retrigger();
    do_reset();
    send(8'h90, 7'd60, 7'd100); wait_note();
    checks++; if (voice_trig !== 4'b0001) begin failures++; $display("FAIL retrig_first got %h want 1", voice_trig); end
    send(8'h90, 7'd60, 7'd90); wait_note();
    checks++; if (voice_trig !== 4'b0001) begin failures++; $display("FAIL retrig_second got %h want 1", voice_trig); end
    checks++; if (voice_gate !== 4'b0001) begin failures++; $display("FAIL retrig_gate got %h want 1", voice_gate); end
    checks++; if (voice_vel[6:0] !== 7'd90) begin failures++; $display("FAIL retrig_vel got %0d want 90", voice_vel[6:0]); end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    send(8'h90, 7'd60, 7'd100); wait_note();
    send(8'h90, 7'd62, 7'd100);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (voice_gate !== 4'b0) begin failures++; $display("FAIL rstscan_gate got %h want 0", voice_gate); end
    checks++; if (voice_note !== 28'b0) begin failures++; $display("FAIL rstscan_note got %h want 0", voice_note); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstscan_ready got %b want 1", in_ready); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (voice_gate !== 4'b0) begin failures++; $display("FAIL rstscan_discard got %h want 0", voice_gate); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'h90, 7'd60, 7'd100); wait_note();
    send(8'h90, 7'd64, 7'd100); wait_note();
    send(8'hB0, 7'd64, 7'd127);
    send(8'hB0, 7'd123, 7'd0);
    checks++; if (voice_gate !== 4'b0) begin failures++; $display("FAIL ano_gate got %h want 0", voice_gate); end
    // Sustain must have been cleared too: a fresh note-off releases immediately
    send(8'h90, 7'd67, 7'd80); wait_note();
    send(8'h80, 7'd67, 7'd0); wait_note();
    checks++; if (voice_gate !== 4'b0) begin failures++; $display("FAIL ano_sus got %h want 0", voice_gate); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_fill_and_steal();
    test_note_off_vel0();
    test_sustain();
    test_channel_filter();
    test_retrigger();
    test_reset_mid_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
